// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg: shared types and constants for the audio stream controller
//   state_t    : transaction FSM states
//   MODE_*     : processing mode encodings of the 2-bit mode input
//   DEF_DATA_W : default per-channel sample width
package audio_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_POP, S_PROC, S_WAIT, S_WRITE} state_t;
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_MUTE  = 2'd1;
  localparam logic [1:0] MODE_TONE  = 2'd2;
  localparam logic [1:0] MODE_ATTEN = 2'd3;
  localparam int DEF_DATA_W = 24;
endpackage

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: square-wave tone source, one step per processed sample
//   CLOCK_50 : clock
//   resetn   : async active-low reset (counter 0, phase positive)
//   advance  : one-cycle pulse per processed sample
//   tone     : +TONE_AMP or -TONE_AMP depending on the current phase
module audio_tone_gen
  import audio_ctrl_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 TONE_HALF = 24,
  parameter logic [DATA_W-1:0]  TONE_AMP  = 'h100000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     advance,
  output logic signed [DATA_W-1:0] tone
);
  localparam int CNT_W = TONE_HALF > 1 ? $clog2(TONE_HALF) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             w_wrap;
  assign w_wrap = r_cnt == CNT_W'(TONE_HALF - 1);
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_cnt <= '0;
      r_neg <= 1'b0;
    end else if (advance) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_neg <= r_neg ^ w_wrap;
    end
  assign tone = r_neg ? -$signed(TONE_AMP) : $signed(TONE_AMP);
endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: sequences codec ADC pop -> process -> DAC push, one stereo sample per transaction
//   CLOCK_50, resetn          : clock, async active-low reset
//   enable                    : gates the start of a new transaction only
//   mode, atten               : processing select and shift amount, sampled in S_PROC
//   read_ready, readdata_*    : ADC FIFO status and head data
//   write_ready               : DAC FIFO not full
//   read, write               : one-cycle pop / push strobes (registered)
//   writedata_*               : processed DAC data, held between transactions
//   busy                      : FSM away from S_IDLE
//   sample_cnt, drop_cnt      : samples written (wraps), samples dropped on timeout (saturates)
module audio_stream_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                TONE_HALF = 24,
  parameter logic [DATA_W-1:0] TONE_AMP  = 'h100000,
  parameter int                TIMEOUT   = 4096
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [2:0]        atten,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic              write_ready,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic [15:0]       sample_cnt,
  output logic [7:0]        drop_cnt
);
  localparam int WAIT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t                   r_state, w_next;
  logic signed [DATA_W-1:0] r_hold_l, r_hold_r;
  logic        [WAIT_W-1:0] r_wait;
  logic signed [DATA_W-1:0] w_tone, w_att_l, w_att_r;
  logic        [DATA_W-1:0] w_wd_l, w_wd_r;
  logic w_go, w_proc, w_timeout, w_read_n, w_write_n, w_busy_n, w_drop;
  assign w_go      = enable && read_ready;
  assign w_timeout = r_wait == WAIT_W'(TIMEOUT - 1);
  assign w_proc    = r_state == S_PROC;
  // shifts kept in their own signed nets so the mode mux cannot turn them logical
  assign w_att_l = r_hold_l >>> atten;
  assign w_att_r = r_hold_r >>> atten;
  audio_tone_gen #(
    .DATA_W   (DATA_W),
    .TONE_HALF(TONE_HALF),
    .TONE_AMP (TONE_AMP)
  ) u_tone (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .advance (w_proc),
    .tone    (w_tone)
  );
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_go ? S_POP : S_IDLE;
      S_POP:   w_next = S_PROC;
      S_PROC:  w_next = S_WAIT;
      S_WAIT:  w_next = write_ready ? S_WRITE : (w_timeout ? S_IDLE : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  // next values of the registered outputs: strobes are high while the FSM sits in S_POP / S_WRITE
  always_comb begin
    w_read_n  = r_state == S_IDLE && w_go;
    w_write_n = r_state == S_WAIT && write_ready;
    w_drop    = r_state == S_WAIT && !write_ready && w_timeout;
    w_busy_n  = w_next != S_IDLE;
    w_wd_l = mode == MODE_MUTE  ? '0 :
             mode == MODE_TONE  ? w_tone :
             mode == MODE_ATTEN ? w_att_l : r_hold_l;
    w_wd_r = mode == MODE_MUTE  ? '0 :
             mode == MODE_TONE  ? w_tone :
             mode == MODE_ATTEN ? w_att_r : r_hold_r;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      read            <= 1'b0;
      write           <= 1'b0;
      busy            <= 1'b0;
      r_hold_l        <= '0;
      r_hold_r        <= '0;
      r_wait          <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      sample_cnt      <= '0;
      drop_cnt        <= '0;
    end else begin
      read  <= w_read_n;
      write <= w_write_n;
      busy  <= w_busy_n;
      if (w_read_n) begin
        r_hold_l <= readdata_left;
        r_hold_r <= readdata_right;
      end
      if (w_proc) begin
        writedata_left  <= w_wd_l;
        writedata_right <= w_wd_r;
      end
      r_wait <= w_proc ? '0 : (r_state == S_WAIT ? r_wait + 1'b1 : r_wait);
      if (r_state == S_WRITE) sample_cnt <= sample_cnt + 16'd1;
      if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
- Sequences the audio_codec read/write handshake on CLOCK_50: pops one stereo ADC sample, processes it, and pushes one stereo DAC sample.
- Sits between audio_codec and the user-facing switches. It replaces the ad-hoc combinational read/write glue.
- Processing modes: passthrough, mute, test tone, attenuated passthrough.
- Exposes status counters: samples processed and samples dropped on DAC timeout.

Parameters:
- DATA_W, 24, sample width per channel (two's complement).
- TONE_HALF, 24, samples per tone half-period (48 kHz / 48 = 1 kHz square wave).
- TONE_AMP, 24'h100000, tone magnitude (positive value, must be < 2^(DATA_W-1)).
- TIMEOUT, 4096, max CLOCK_50 cycles spent waiting for write_ready before a sample is dropped.

Ports:
- CLOCK_50, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- enable, in, 1, allow new sample transactions.
- mode, in, 2, 00 passthrough, 01 mute, 10 tone, 11 attenuate.
- atten, in, 3, arithmetic right-shift amount for mode 11.
- read_ready, in, 1, codec ADC FIFO non-empty; head data valid.
- readdata_left, in, DATA_W, ADC FIFO head, left channel.
- readdata_right, in, DATA_W, ADC FIFO head, right channel.
- write_ready, in, 1, codec DAC FIFO not full.
- read, out, 1, one-cycle pop of the ADC FIFO.
- write, out, 1, one-cycle push to the DAC FIFO.
- writedata_left, out, DATA_W, DAC data, left channel.
- writedata_right, out, DATA_W, DAC data, right channel.
- busy, out, 1, FSM not in S_IDLE.
- sample_cnt, out, 16, count of samples written; wraps.
- drop_cnt, out, 8, count of samples dropped on timeout; saturates at 255.

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to S_IDLE.
  - All outputs are 0, including counters and writedata.
  - Tone counter is 0 and tone phase is positive.
- All outputs are registered. read and write are each high for exactly one cycle per transaction and never high in the same cycle.
- S_IDLE:
  - If enable && read_ready: capture readdata_left/right into hold registers and go to S_POP.
  - Otherwise stay in S_IDLE.
- S_POP: read=1 for this cycle only; go to S_PROC.
- S_PROC:
  - Sample mode and atten here. Changes made mid-transaction affect only the next sample.
  - Load writedata_left/right:
    - 00: hold values.
    - 01: 0.
    - 10: +TONE_AMP or -TONE_AMP by phase, same value on both channels.
    - 11: hold >>> atten (sign-extended).
  - Advance the tone counter in every mode. At TONE_HALF-1, wrap the counter to 0 and invert the phase.
  - Clear the wait counter. Go to S_WAIT.
- S_WAIT:
  - If write_ready: go to S_WRITE.
  - Else if wait counter == TIMEOUT-1: drop_cnt += 1 (saturating at 255), no write, go to S_IDLE.
  - Else increment the wait counter.
- S_WRITE: write=1 for this cycle only; sample_cnt += 1 (16-bit wrap); go to S_IDLE.
- Latency: minimum 4 cycles from read_ready sampled in S_IDLE to write asserted. The minimum transaction is 5 cycles including the return to S_IDLE.
- At least 3 cycles separate read and re-entry to S_IDLE, so read_ready is settled before it is re-evaluated.
- enable deasserted mid-transaction: the current sample completes normally. enable only gates the S_IDLE → S_POP transition.
- writedata holds its last value between transactions and after a drop.
- A timeout drop never asserts write and leaves sample_cnt unchanged.
- Reset mid-transaction: immediate return to reset values; no partial read/write pulse is emitted.

Decomposition:
- Package audio_ctrl_pkg holds:
  - state enum: S_IDLE, S_POP, S_PROC, S_WAIT, S_WRITE;
  - mode encodings: MODE_PASS, MODE_MUTE, MODE_TONE, MODE_ATTEN;
  - default DATA_W.
- One sub-module, audio_tone_gen, contains the tone counter and phase register. Inputs are advance (pulsed in S_PROC) and resetn. Output is a signed DATA_W tone sample.

Test Plan:
- Passthrough: mode=00, read_ready=1 with L=24'h123456, R=24'hFEDCBA, write_ready=1 → read pulse in cycle 1 after capture, write pulse 3 cycles later, writedata=123456/FEDCBA, sample_cnt=1.
- Attenuate: mode=11, atten=3, L=24'hF00000 → writedata_left=24'hFE0000 (sign kept).
- Tone: mode=10, 48 back-to-back samples → first 24 writes +24'h100000, next 24 writes -24'h100000 (24'hF00000), then repeats.
- Timeout: write_ready held 0 for 5000 cycles after one read → no write, drop_cnt=1 at cycle TIMEOUT after entering S_WAIT, FSM back in S_IDLE; 300 forced drops → drop_cnt=255.
- Enable/mode mid-transaction: drop enable and change mode 00→01 during S_WAIT → pending sample written with passthrough data; no further read while enable=0.
- Async reset: assert resetn=0 in S_WAIT → outputs 0 immediately, busy=0, no write pulse after release.
